// File: rtl/tinyalu_responder.sv
// tinyalu_responder: TinyALU start/done responder with add/and/xor (1 cycle) and mul (MUL_LATENCY cycles).
// Optional illegal-op reporting (err port) is enabled by defining TINYALU_ILLEGAL_OP_EN.
module tinyalu_responder #(
  parameter int DATA_W      = 8,
  parameter int MUL_LATENCY = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   A,
  input  logic [DATA_W-1:0]   B,
  input  logic [2:0]          op,
  input  logic                start,
  output logic                done,
  output logic [2*DATA_W-1:0] result
`ifdef TINYALU_ILLEGAL_OP_EN
  ,
  output logic                err
`endif
);
  localparam int W2 = 2 * DATA_W;
  typedef enum logic [1:0] {IDLE, BUSY, DONE, WAIT_REL} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              armed_q, armed_d;
  logic [W2-1:0]     result_q, result_d;
  logic [W2-1:0]     ax, bx, alu;
  logic              legal;
`ifdef TINYALU_ILLEGAL_OP_EN
  logic              err_q, err_d;
  logic              illegal;
  assign illegal = start && armed_q && (op == 3'd5 || op == 3'd6);
  assign err     = err_q;
`endif
  assign ax     = W2'(a_q);
  assign bx     = W2'(b_q);
  assign alu    = op_q == 3'd1 ? ax + bx : op_q == 3'd2 ? ax & bx : op_q == 3'd3 ? ax ^ bx : ax * bx;
  // armed drops only when start is held through reset, so a held start never fires an op
  assign legal  = start && armed_q && op >= 3'd1 && op <= 3'd4;
  assign done   = done_q;
  assign result = result_q;
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;
    armed_d  = armed_q | ~start;
`ifdef TINYALU_ILLEGAL_OP_EN
    err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (legal) begin
          a_d     = A;
          b_d     = B;
          op_d    = op;
          cnt_d   = op == 3'd4 ? 4'(MUL_LATENCY) : 4'd1;
          state_d = BUSY;
        end
`ifdef TINYALU_ILLEGAL_OP_EN
        else if (illegal) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end
`endif
      end
      BUSY: begin
        if (!start) state_d = IDLE;
        else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            result_d = alu;
            done_d   = 1'b1;
            state_d  = DONE;
          end
        end
      end
      DONE:     state_d = start ? WAIT_REL : IDLE;
      WAIT_REL: state_d = start ? WAIT_REL : IDLE;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      armed_q  <= ~start;
`ifdef TINYALU_ILLEGAL_OP_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      armed_q  <= armed_d;
`ifdef TINYALU_ILLEGAL_OP_EN
      err_q    <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_tinyalu_responder.sv
// tb_tinyalu_responder: directed plus random operations checked against an arithmetic reference model.
module tb_tinyalu_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  A = '0, B = '0;
  logic [2:0]  op = '0;
  logic        start = 1'b0;
  logic        done;
  logic [15:0] result;
`ifdef TINYALU_ILLEGAL_OP_EN
  logic        err;
`endif
  int total = 0, bad = 0;
  logic [15:0] model_res = '0;

  tinyalu_responder dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .op(op), .start(start),
    .done(done), .result(result)
`ifdef TINYALU_ILLEGAL_OP_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_alu(input logic [2:0] o, input int a, input int b);
    case (o)
      3'd1: return 16'(a + b);
      3'd2: return 16'(a & b);
      3'd3: return 16'(a ^ b);
      3'd4: return 16'(a * b);
      default: return model_res;
    endcase
  endfunction

  task automatic do_op(input string tag, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input int hold);
    int n = 0;
    int lat = (o == 3'd4) ? 3 : 1;
    int extra = 0;
    logic e = (o == 3'd5 || o == 3'd6);
    model_res = ref_alu(o, int'(a), int'(b));
    A = a; B = b; op = o; start = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick;
      if (done) begin n = i; break; end
      A = 8'(~a); B = 8'(a + b);
    end
    check({tag, "_latency"}, n, lat + 1);
    check({tag, "_result"}, result, model_res);
`ifdef TINYALU_ILLEGAL_OP_EN
    check({tag, "_err"}, err, e);
`else
    if (e) check({tag, "_noerr_build"}, n, 0);
`endif
    for (int i = 0; i < hold; i++) begin
      tick;
      extra += done;
    end
    start = 1'b0;
    tick;
    extra += done;
    check({tag, "_single_pulse"}, extra, 0);
  endtask

  task automatic ignored(input string tag, input logic [2:0] o);
    int seen = 0;
    op = o; A = 8'h5A; B = 8'hA5; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      seen += done;
    end
    start = 1'b0;
    tick;
    seen += done;
    check({tag, "_no_done"}, seen, 0);
    check({tag, "_result_kept"}, result, model_res);
  endtask

  initial begin
    int seen;
    start = 1'b1; op = 3'd1; A = 8'd1; B = 8'd1;
    tick; tick;
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      seen += done;
    end
    check("held_start_after_reset", seen, 0);
    start = 1'b0;
    tick;
    do_op("add_after_release", 3'd1, 8'd1, 8'd1, 0);
    do_op("add_ff", 3'd1, 8'hFF, 8'hFF, 0);
    check("add_ff_value", result, 16'h01FE);
    do_op("and_ff", 3'd2, 8'hFF, 8'hFF, 0);
    check("and_ff_value", result, 16'h00FF);
    do_op("xor_ff", 3'd3, 8'hFF, 8'hFF, 0);
    check("xor_ff_value", result, 16'h0000);
    do_op("mul_ff", 3'd4, 8'hFF, 8'hFF, 2);
    check("mul_ff_value", result, 16'hFE01);
    do_op("hold5", 3'd1, 8'd7, 8'd9, 5);
    tick;
    do_op("mul_3x4", 3'd4, 8'd3, 8'd4, 0);
    check("mul_3x4_value", result, 16'h000C);
    A = 8'd9; B = 8'd9; op = 3'd4; start = 1'b1;
    tick; tick;
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      seen += done;
    end
    check("abort_drop_no_done", seen, 0);
    check("abort_drop_result", result, 16'h000C);
    start = 1'b1;
    tick; tick;
    reset = 1'b1; start = 1'b0;
    tick;
    reset = 1'b0;
    model_res = '0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      seen += done;
    end
    check("abort_reset_no_done", seen, 0);
    check("abort_reset_result", result, 0);
    do_op("add_1_2", 3'd1, 8'd1, 8'd2, 0);
    check("add_1_2_value", result, 16'h0003);
    ignored("no_op", 3'd0);
    ignored("op7", 3'd7);
`ifdef TINYALU_ILLEGAL_OP_EN
    do_op("illegal_101", 3'd5, 8'd8, 8'd8, 1);
    check("illegal_result_kept", result, 16'h0003);
`else
    ignored("op5", 3'd5);
    ignored("op6", 3'd6);
`endif
    for (int k = 0; k < 40; k++) begin
      logic [2:0] ro = 3'(1 + $urandom_range(3));
      do_op("rand", ro, 8'($urandom), 8'($urandom), int'($urandom_range(2)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
